// File: rtl/mux_rr_pipe.sv
// Round-robin N-channel multiplexer with a single registered output stage.
// Optional channel-index output is enabled by defining MUX_RR_PIPE_CHAN_ID_EN.
module mux_rr_pipe #(
  parameter int Nbits = 32,
  parameter int Nch   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [Nch*Nbits-1:0]   data_i,
  input  logic [Nch-1:0]         valid_i,
  output logic [Nch-1:0]         ready_o,
  output logic [Nbits-1:0]       data_o,
  output logic                   valid_o,
  input  logic                   ready_i
`ifdef MUX_RR_PIPE_CHAN_ID_EN
  ,
  output logic [$clog2(Nch)-1:0] chan_o
`endif
);

  localparam int PW = $clog2(Nch);
  localparam logic [PW-1:0] PTR_RST = PW'(Nch - 1);

  // Channel index reached by stepping 'off' positions past p, wrapping at Nch.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    return PW'(s % Nch);
  endfunction

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [Nbits-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [PW-1:0]    gnt_idx_s;
  logic             gnt_vld_s;
  logic             load_s;
  logic             in_xfer_s;
  logic [Nbits-1:0] sel_data_s;
  logic [Nch-1:0]   ready_s;

  // Round-robin search; scanning farthest-first lets the nearest requester win.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_idx_s = '0;
    for (int i = Nch; i >= 1; i--) begin
      if (valid_i[wrap_add(ptr_q, i)]) begin
        gnt_vld_s = 1'b1;
        gnt_idx_s = wrap_add(ptr_q, i);
      end else begin
        gnt_vld_s = gnt_vld_s;
      end
    end
  end

  // Data steering for the granted channel.
  always_comb begin
    sel_data_s = '0;
    for (int k = 0; k < Nch; k++) begin
      if (gnt_idx_s == PW'(k)) begin
        sel_data_s = data_i[k*Nbits +: Nbits];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  assign load_s    = ~valid_q | ready_i;
  assign in_xfer_s = load_s & gnt_vld_s;

  // One-hot accept, forced low while reset is asserted.
  always_comb begin
    ready_s = '0;
    for (int k = 0; k < Nch; k++) begin
      ready_s[k] = rst_n & in_xfer_s & (gnt_idx_s == PW'(k));
    end
  end

  assign ready_o = ready_s;

  // Output-stage next state: reload on accept, drain on output transfer, else hold.
  always_comb begin
    ptr_d   = ptr_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (in_xfer_s) begin
      ptr_d   = gnt_idx_s;
      data_d  = sel_data_s;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output-stage and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= PTR_RST;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

`ifdef MUX_RR_PIPE_CHAN_ID_EN
  logic [PW-1:0] chan_q, chan_d;

  // Channel index follows the data register's load enable.
  always_comb begin
    if (in_xfer_s) begin
      chan_d = gnt_idx_s;
    end else begin
      chan_d = chan_q;
    end
  end

  // Channel index register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chan_q <= '0;
    end else begin
      chan_q <= chan_d;
    end
  end

  assign chan_o = chan_q;
`endif

endmodule

// File: doc/mux_rr_pipe.md
MUX_RR_PIPE -- requirements
Module: mux_rr_pipe

Interface
REQ-001 Parameter Nbits, default 32, data width of every channel and of the output.
REQ-002 Parameter Nch, default 4, number of input channels; legal range 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 data_i  input  Nch*Nbits  packed channel data; channel k occupies bits [k*Nbits+Nbits-1 : k*Nbits].
REQ-006 valid_i  input  Nch  per-channel request; bit k qualifies channel k data.
REQ-007 ready_o  output  Nch  per-channel accept; one-hot or zero.
REQ-008 data_o  output  Nbits  registered selected data.
REQ-009 valid_o  output  1  output register holds a word.
REQ-010 ready_i  input  1  downstream accept.
REQ-011 chan_o  output  clog2(Nch)  index of the channel that produced data_o; present only per REQ-030.

Function
REQ-012 The output register has two states: EMPTY (valid_o=0) and FULL (valid_o=1).
REQ-013 load = ~valid_o | ready_i; a new word may be captured only in cycles where load=1.
REQ-014 Transfer on channel k occurs when valid_i[k] & ready_o[k]; output transfer occurs when valid_o & ready_i.
REQ-015 ready_o[k]=1 only when load=1 and k is the grant; ready_o is combinational from valid_i, pointer and load.
REQ-016 Grant = first channel with valid_i set, searching from (ptr+1) mod Nch upward with wrap to 0.
REQ-017 ready_o shall not depend on valid_i of the granted channel being held beyond the transfer cycle (no combinational loop through ready_i to valid_i is assumed or created).
REQ-018 On an input transfer from channel k: data_o <= channel k data, valid_o <= 1, ptr <= k, next cycle.
REQ-019 Latency input transfer to valid_o = 1 cycle.
REQ-020 Output transfer with no input transfer in the same cycle: valid_o <= 0, data_o holds its value.
REQ-021 Simultaneous output transfer and input transfer: register reloads, valid_o stays 1; sustained throughput 1 word per cycle.
REQ-022 FULL with ready_i=0: data_o, valid_o, ptr held; all ready_o=0 (backpressure).
REQ-023 No valid_i set: all ready_o=0, ptr held.
REQ-024 Pointer wrap: ptr=Nch-1 searches from channel 0.
REQ-025 Fairness: any channel holding valid_i continuously is granted within Nch input transfers.
REQ-026 Single requester granted every load cycle regardless of ptr.

Reset
REQ-027 While rst_n=0: valid_o=0, data_o=0, ptr=Nch-1, chan_o=0 (if present), ready_o=0, asynchronously.
REQ-028 Reset asserted mid-transfer discards the held word; first grant after release starts search at channel 0.
REQ-029 Deassertion is taken as synchronous to clk by the integrator; no internal synchroniser.

Configuration
REQ-030 Macro MUX_RR_PIPE_CHAN_ID_EN: when defined, port chan_o exists and registers the granted index alongside data_o (same load enable, reset 0); when undefined, port chan_o and its register are absent and all other behaviour is identical.

Verification
REQ-031 Nch=4, Nbits=8, reset then valid_i=4'b1111 with data 0x10,0x11,0x12,0x13, ready_i=1 -> data_o sequence 0x10,0x11,0x12,0x13,0x10 on consecutive cycles, first valid_o one cycle after the first accept.
REQ-032 Backpressure: valid_o=1, data_o=0xA5, ready_i=0 for 5 cycles with valid_i=4'b0110 -> data_o stays 0xA5, ready_o=0 all 5 cycles; ready_i=1 -> next grant is per REQ-016 from the held ptr.
REQ-033 Wrap: ptr=3, valid_i=4'b1001 -> grant channel 0, then channel 3, then channel 0.
REQ-034 Reset mid-stream: rst_n low asynchronously while valid_o=1 -> valid_o=0, data_o=0 immediately, before the next edge; after release with valid_i=4'b1000 -> channel 3 granted on the first load cycle.
REQ-035 Single requester valid_i=4'b0100 held, ready_i=1 -> ready_o=4'b0100 every cycle, valid_o=1 continuously from cycle 2.
REQ-036 With MUX_RR_PIPE_CHAN_ID_EN defined, rerun REQ-031 -> chan_o = 0,1,2,3,0 aligned with data_o.
